// File: rtl/vga_timing_gen_if.sv
// Host-side pixel bus of vga_timing_gen: fetch request, active-window
// coordinates and frame strobe out to the frame-buffer reader, colour data back.
interface vga_timing_gen_if #(
    parameter int unsigned COLOR_W = 10,
    parameter int unsigned CNT_W   = 12
);
    logic               oRequest;
    logic [CNT_W-1:0]   oX;
    logic [CNT_W-1:0]   oY;
    logic               oFrameStart;
    logic [COLOR_W-1:0] iRed;
    logic [COLOR_W-1:0] iGreen;
    logic [COLOR_W-1:0] iBlue;

    // Timing generator side
    modport master (
        output oRequest, oX, oY, oFrameStart,
        input  iRed, iGreen, iBlue
    );

    // Frame-buffer reader side
    modport slave (
        input  oRequest, oX, oY, oFrameStart,
        output iRed, iGreen, iBlue
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing and pixel-output stage.
// Generates sync/blank, an early fetch request, active-window coordinates and
// a frame-start strobe, and gates host colour onto the DAC outputs.
// Optional feature macro: VGA_TEST_PATTERN_EN adds input iPattern and an
// 8-bar colour generator selected on a frame-aligned basis.
module vga_timing_gen #(
    parameter int unsigned COLOR_W  = 10,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_ACT    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACT    = 480,
    parameter int unsigned V_FP     = 10,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned REQ_LEAD = 2,
    parameter int unsigned CNT_W    = 12
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iEN,
    vga_timing_gen_if.master   host,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               iPattern,
`endif
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_H_SYNC,
    output logic               oVGA_V_SYNC,
    output logic               oVGA_BLANK,
    output logic               oVGA_SYNC,
    output logic               oVGA_CLOCK
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned H_END   = H_START + H_ACT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned V_END   = V_START + V_ACT;
    localparam int unsigned LEAD_W  = CNT_W + 1;
    localparam int unsigned BAR_W   = CNT_W + 3;

    logic [CNT_W-1:0]   h_cnt;
    logic [CNT_W-1:0]   v_cnt;
    logic               h_wrap_c;
    logic               v_wrap_c;

    logic [LEAD_W-1:0]  h_lead_c;
    logic               h_act_c;
    logic               v_act_c;
    logic               act_c;
    logic               req_c;
    logic               origin_c;
    logic [CNT_W-1:0]   x_c;
    logic [CNT_W-1:0]   y_c;
    logic [COLOR_W-1:0] r_c;
    logic [COLOR_W-1:0] g_c;
    logic [COLOR_W-1:0] b_c;

    logic               req_q;
    logic               fs_q;
    logic [CNT_W-1:0]   x_q;
    logic [CNT_W-1:0]   y_q;

`ifdef VGA_TEST_PATTERN_EN
    logic               pattern_q;
    logic [2:0]         bar_c;
`endif

    assign h_wrap_c = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_wrap_c = (v_cnt == CNT_W'(V_TOTAL - 1));

    // Raster counters: h advances every enabled cycle, v on each h wrap
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (iEN) begin
            if (h_wrap_c) begin
                h_cnt <= '0;
                v_cnt <= v_wrap_c ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    // Decode window, look-ahead request and pixel source for the current position
    always_comb begin
        h_lead_c = {1'b0, h_cnt} + LEAD_W'(REQ_LEAD);
        h_act_c  = (h_cnt >= CNT_W'(H_START)) && (h_cnt < CNT_W'(H_END));
        v_act_c  = (v_cnt >= CNT_W'(V_START)) && (v_cnt < CNT_W'(V_END));
        act_c    = h_act_c && v_act_c;
        // Look-ahead stays within the line: positions past H_TOTAL never match
        req_c    = (h_lead_c >= LEAD_W'(H_START)) && (h_lead_c < LEAD_W'(H_END)) && v_act_c;
        origin_c = (h_cnt == '0) && (v_cnt == '0);
        x_c      = act_c ? h_cnt - CNT_W'(H_START) : '0;
        y_c      = act_c ? v_cnt - CNT_W'(V_START) : '0;
        r_c      = '0;
        g_c      = '0;
        b_c      = '0;
        if (act_c) begin
            r_c = host.iRed;
            g_c = host.iGreen;
            b_c = host.iBlue;
        end
`ifdef VGA_TEST_PATTERN_EN
        bar_c = 3'({x_c, 3'b000} / BAR_W'(H_ACT));
        if (pattern_q) begin
            req_c = 1'b0;
            if (act_c) begin
                r_c = {COLOR_W{bar_c[2]}};
                g_c = {COLOR_W{bar_c[1]}};
                b_c = {COLOR_W{bar_c[0]}};
            end
        end
`endif
    end

`ifdef VGA_TEST_PATTERN_EN
    // Pattern select is captured at the frame origin so switching is frame-aligned
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pattern_q <= 1'b0;
        end else if (iEN && origin_c) begin
            pattern_q <= iPattern;
        end
    end
`endif

    // Register every raster-derived output; all hold while iEN is low
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            req_q       <= 1'b0;
            fs_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            oVGA_R      <= '0;
            oVGA_G      <= '0;
            oVGA_B      <= '0;
            oVGA_BLANK  <= 1'b0;
            oVGA_H_SYNC <= ~H_POL;
            oVGA_V_SYNC <= ~V_POL;
        end else if (iEN) begin
            req_q       <= req_c;
            fs_q        <= origin_c;
            x_q         <= x_c;
            y_q         <= y_c;
            oVGA_R      <= r_c;
            oVGA_G      <= g_c;
            oVGA_B      <= b_c;
            oVGA_BLANK  <= act_c;
            oVGA_H_SYNC <= (h_cnt < CNT_W'(H_SYNC)) ? H_POL : ~H_POL;
            oVGA_V_SYNC <= (v_cnt < CNT_W'(V_SYNC)) ? V_POL : ~V_POL;
        end
    end

    assign host.oRequest    = req_q;
    assign host.oFrameStart = fs_q;
    assign host.oX          = x_q;
    assign host.oY          = y_q;
    assign oVGA_SYNC        = 1'b0;
    assign oVGA_CLOCK       = iCLK;

endmodule
